// File: rtl/dual_issue_scheduler_pkg.sv
// sched_pkg: RV32I opcodes and the decoded-instruction view used by the dual-issue scheduler.
package sched_pkg;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       writes_rd;
        logic       is_load;
        logic       is_mem;
        logic       is_ctrl;
    } decoded_instr_t;
endpackage

// File: rtl/dual_issue_scheduler_if.sv
// dual_issue_scheduler_if: fetch-buffer head slots, hold signals and registered issue slots.
// SCHED_PERF_EN adds the perf_dual/perf_single/perf_stall counter outputs.
interface dual_issue_scheduler_if;
    logic        nothing_filled;
    logic [31:0] instruction0;
    logic [31:0] instruction1;
    logic        ex_stall;
    logic        flush;
    logic        freeze1;
    logic        freeze2;
    logic        dependency_on_ins2;
    logic        issue0_valid;
    logic [31:0] issue0_instr;
    logic        issue1_valid;
    logic [31:0] issue1_instr;
`ifdef SCHED_PERF_EN
    logic [31:0] perf_dual;
    logic [31:0] perf_single;
    logic [31:0] perf_stall;

    modport master (
        output nothing_filled, instruction0, instruction1, ex_stall, flush,
        input  freeze1, freeze2, dependency_on_ins2,
        input  issue0_valid, issue0_instr, issue1_valid, issue1_instr,
        input  perf_dual, perf_single, perf_stall
    );
    modport slave (
        input  nothing_filled, instruction0, instruction1, ex_stall, flush,
        output freeze1, freeze2, dependency_on_ins2,
        output issue0_valid, issue0_instr, issue1_valid, issue1_instr,
        output perf_dual, perf_single, perf_stall
    );
`else
    modport master (
        output nothing_filled, instruction0, instruction1, ex_stall, flush,
        input  freeze1, freeze2, dependency_on_ins2,
        input  issue0_valid, issue0_instr, issue1_valid, issue1_instr
    );
    modport slave (
        input  nothing_filled, instruction0, instruction1, ex_stall, flush,
        output freeze1, freeze2, dependency_on_ins2,
        output issue0_valid, issue0_instr, issue1_valid, issue1_instr
    );
`endif
endinterface

// File: rtl/dual_issue_scheduler_instr_decode.sv
// instr_decode: combinational RV32I register-usage decode; x0 never counts as a source or destination.
module instr_decode
    import sched_pkg::*;
(
    input  logic [31:0]    i_instr,
    output decoded_instr_t o_dec
);
    logic [6:0] w_opc;
    logic       w_rd_only;
    logic       w_rs1_rd;
    logic       w_no_rd;

    assign w_opc     = i_instr[6:0];
    assign w_rd_only = w_opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL};
    assign w_rs1_rd  = w_opc inside {OPC_JALR, OPC_LOAD, OPC_OPIMM};
    assign w_no_rd   = w_opc inside {OPC_BRANCH, OPC_STORE};

    // Anything not matched above (OP and unknown opcodes) reads rs1/rs2 and writes rd
    always_comb begin
        o_dec.rd        = i_instr[11:7];
        o_dec.rs1       = i_instr[19:15];
        o_dec.rs2       = i_instr[24:20];
        o_dec.uses_rs1  = !w_rd_only && i_instr[19:15] != 5'd0;
        o_dec.uses_rs2  = !w_rd_only && !w_rs1_rd && i_instr[24:20] != 5'd0;
        o_dec.writes_rd = !w_no_rd && i_instr[11:7] != 5'd0;
        o_dec.is_load   = w_opc == OPC_LOAD;
        o_dec.is_mem    = w_opc == OPC_LOAD || w_opc == OPC_STORE;
        o_dec.is_ctrl   = w_opc inside {OPC_BRANCH, OPC_JAL, OPC_JALR};
    end
endmodule

// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler: issues 0/1/2 head instructions per cycle using a per-register load scoreboard.
// SCHED_PERF_EN adds dual/single/stall cycle counters.
module dual_issue_scheduler
    import sched_pkg::*;
#(
    parameter int LOAD_LATENCY = 2,
    parameter int NUM_REGS     = 32
)(
    input logic                  clk,
    input logic                  rst_n,
    dual_issue_scheduler_if.slave bus
);
    localparam int CW = $clog2(LOAD_LATENCY + 1);

    decoded_instr_t w_d0;
    decoded_instr_t w_d1;
    logic [CW-1:0]  r_sb [NUM_REGS];
    logic           w_h0;
    logic           w_h1;
    logic           w_pb;
    logic           w_kill;
    logic           w_run;
    logic           w_iss0;
    logic           w_iss1;
    logic           r_v0;
    logic           r_v1;
    logic [31:0]    r_i0;
    logic [31:0]    r_i1;

    instr_decode u_dec0 (.i_instr(bus.instruction0), .o_dec(w_d0));
    instr_decode u_dec1 (.i_instr(bus.instruction1), .o_dec(w_d1));

    assign w_h0 = (w_d0.uses_rs1 && r_sb[w_d0.rs1] != '0) || (w_d0.uses_rs2 && r_sb[w_d0.rs2] != '0);
    assign w_h1 = (w_d1.uses_rs1 && r_sb[w_d1.rs1] != '0) || (w_d1.uses_rs2 && r_sb[w_d1.rs2] != '0);

    assign w_pb = (w_d0.writes_rd && ((w_d1.uses_rs1 && w_d1.rs1 == w_d0.rd) ||
                                      (w_d1.uses_rs2 && w_d1.rs2 == w_d0.rd) ||
                                      (w_d1.writes_rd && w_d1.rd == w_d0.rd))) ||
                  w_d0.is_ctrl || (w_d0.is_mem && w_d1.is_mem) || w_h1 || bus.instruction1 == '0;

    assign w_kill = bus.nothing_filled || bus.flush;
    assign w_run  = !w_kill && !bus.ex_stall;
    assign w_iss0 = w_run && !w_h0;
    assign w_iss1 = w_iss0 && !w_pb;

    assign bus.freeze2            = !w_kill && bus.ex_stall;
    assign bus.freeze1            = w_run && w_h0;
    assign bus.dependency_on_ins2 = w_iss0 && w_pb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_i0 <= '0;
            r_i1 <= '0;
        end else if (!bus.ex_stall || w_kill) begin
            r_v0 <= w_iss0;
            r_v1 <= w_iss1;
            if (w_iss0) r_i0 <= bus.instruction0;
            if (w_iss1) r_i1 <= bus.instruction1;
        end
    end

    // A load issued this edge overrides the countdown of its destination
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) r_sb[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                r_sb[r] <= ((w_iss0 && w_d0.is_load && w_d0.writes_rd && w_d0.rd == 5'(r)) ||
                            (w_iss1 && w_d1.is_load && w_d1.writes_rd && w_d1.rd == 5'(r)))
                           ? CW'(LOAD_LATENCY) : r_sb[r] - CW'(r_sb[r] != '0);
        end
    end

    assign bus.issue0_valid = r_v0;
    assign bus.issue0_instr = r_i0;
    assign bus.issue1_valid = r_v1;
    assign bus.issue1_instr = r_i1;

`ifdef SCHED_PERF_EN
    logic [31:0] r_perf_dual;
    logic [31:0] r_perf_single;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_dual   <= '0;
            r_perf_single <= '0;
            r_perf_stall  <= '0;
        end else if (!bus.nothing_filled) begin
            r_perf_dual   <= r_perf_dual + 32'(w_iss1);
            r_perf_single <= r_perf_single + 32'(w_iss0 && !w_iss1);
            r_perf_stall  <= r_perf_stall + 32'(!w_iss0);
        end
    end

    assign bus.perf_dual   = r_perf_dual;
    assign bus.perf_single = r_perf_single;
    assign bus.perf_stall  = r_perf_stall;
`endif
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb_dual_issue_scheduler: directed scenarios plus randomized head pairs checked against a ready-time model.
`timescale 1ns/1ps
module tb_dual_issue_scheduler;
    localparam int LL = 2;
    localparam logic [6:0] O_LOAD = 7'b0000011, O_STORE = 7'b0100011, O_BR = 7'b1100011;
    localparam logic [6:0] O_JAL = 7'b1101111, O_JALR = 7'b1100111, O_OP = 7'b0110011;
    localparam logic [6:0] O_IMM = 7'b0010011, O_LUI = 7'b0110111, O_AUIPC = 7'b0010111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dual_issue_scheduler_if bus();
    dual_issue_scheduler #(.LOAD_LATENCY(LL), .NUM_REGS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a register is busy while the current cycle index is before its ready cycle
    int ready [32];
    int cyc = 0;
    logic ev0, ev1;
    logic [31:0] ei0, ei1;
    int m_dual, m_single, m_stall;

    function automatic logic [31:0] enc(input logic [6:0] o, input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), o};
    endfunction

    function automatic void dec(input logic [31:0] w, output int s1, output int s2, output int d,
                                output bit ld, output bit mem, output bit ctl);
        logic [6:0] o;
        o = w[6:0];
        s1 = int'(w[19:15]);
        s2 = int'(w[24:20]);
        d = int'(w[11:7]);
        ld = o == O_LOAD;
        mem = ld || o == O_STORE;
        ctl = o == O_BR || o == O_JAL || o == O_JALR;
        if (o == O_LUI || o == O_AUIPC || o == O_JAL) begin s1 = 0; s2 = 0; end
        if (o == O_JALR || o == O_LOAD || o == O_IMM) s2 = 0;
        if (o == O_BR || o == O_STORE) d = 0;
    endfunction

    function automatic bit busy(input int r);
        return r != 0 && cyc < ready[r];
    endfunction

    function automatic int model_n(input logic [31:0] a, input logic [31:0] b);
        int a1, a2, ad, b1, b2, bd;
        bit al, am, ac, bl, bm, bc;
        dec(a, a1, a2, ad, al, am, ac);
        dec(b, b1, b2, bd, bl, bm, bc);
        if (busy(a1) || busy(a2)) return 0;
        if ((ad != 0 && (b1 == ad || b2 == ad || bd == ad)) || ac || (am && bm) ||
            busy(b1) || busy(b2) || b == 32'd0) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [6:0] ops [10];
        ops = '{O_LOAD, O_STORE, O_BR, O_JAL, O_JALR, O_OP, O_IMM, O_LUI, O_AUIPC, 7'b1111111};
        if ($urandom_range(0, 15) == 0) return 32'd0;
        return enc(ops[$urandom_range(0, 9)], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    endfunction

    task automatic apply(input logic nf, input logic fl, input logic st, input logic [31:0] a, input logic [31:0] b);
        bus.nothing_filled = nf;
        bus.flush = fl;
        bus.ex_stall = st;
        bus.instruction0 = a;
        bus.instruction1 = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int r = 0; r < 32; r++) ready[r] = 0;
        ev0 = 1'b0;
        ev1 = 1'b0;
        ei0 = '0;
        ei1 = '0;
        m_dual = 0;
        m_single = 0;
        m_stall = 0;
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b0;
        #12;
        n_cmp++; if (bus.issue0_valid !== 1'b0) begin n_bad++; $display("FAIL reset_v0: got %b want 0", bus.issue0_valid); end
        n_cmp++; if (bus.issue1_valid !== 1'b0) begin n_bad++; $display("FAIL reset_v1: got %b want 0", bus.issue1_valid); end
        n_cmp++; if (bus.issue0_instr !== 32'd0) begin n_bad++; $display("FAIL reset_i0: got %h want 0", bus.issue0_instr); end
        n_cmp++; if (bus.issue1_instr !== 32'd0) begin n_bad++; $display("FAIL reset_i1: got %h want 0", bus.issue1_instr); end
        n_cmp++; if ({bus.freeze1, bus.freeze2, bus.dependency_on_ins2} !== 3'b000) begin
            n_bad++; $display("FAIL reset_comb: got %b want 000", {bus.freeze1, bus.freeze2, bus.dependency_on_ins2}); end
    endtask

    task automatic test_dual();
        logic [31:0] a, b;
        do_reset();
        a = enc(O_IMM, 1, 0, 1);
        b = enc(O_IMM, 2, 0, 2);
        apply(1'b0, 1'b0, 1'b0, a, b);
        #4;
        n_cmp++; if ({bus.freeze1, bus.freeze2, bus.dependency_on_ins2} !== 3'b000) begin
            n_bad++; $display("FAIL dual_comb: got %b want 000", {bus.freeze1, bus.freeze2, bus.dependency_on_ins2}); end
        tick();
        n_cmp++; if ({bus.issue0_valid, bus.issue1_valid, bus.issue0_instr, bus.issue1_instr} !== {2'b11, a, b}) begin
            n_bad++; $display("FAIL dual_issue: got %b %b %h %h want 1 1 %h %h", bus.issue0_valid, bus.issue1_valid,
                              bus.issue0_instr, bus.issue1_instr, a, b); end
    endtask

    task automatic test_dep();
        logic [31:0] a;
        do_reset();
        a = enc(O_IMM, 1, 0, 1);
        apply(1'b0, 1'b0, 1'b0, a, enc(O_OP, 3, 1, 1));
        #4;
        n_cmp++; if ({bus.freeze1, bus.freeze2, bus.dependency_on_ins2} !== 3'b001) begin
            n_bad++; $display("FAIL dep_comb: got %b want 001", {bus.freeze1, bus.freeze2, bus.dependency_on_ins2}); end
        tick();
        n_cmp++; if ({bus.issue0_valid, bus.issue1_valid, bus.issue0_instr} !== {2'b10, a}) begin
            n_bad++; $display("FAIL dep_issue: got %b %b %h want 1 0 %h", bus.issue0_valid, bus.issue1_valid, bus.issue0_instr, a); end
    endtask

    task automatic test_load_hazard();
        logic [31:0] lw, add, nx;
        do_reset();
        lw = enc(O_LOAD, 5, 0, 0);
        add = enc(O_OP, 6, 5, 0);
        nx = enc(O_IMM, 9, 0, 4);
        apply(1'b0, 1'b0, 1'b0, lw, add);
        tick();
        n_cmp++; if ({bus.issue0_valid, bus.issue1_valid, bus.issue0_instr} !== {2'b10, lw}) begin
            n_bad++; $display("FAIL load_issue: got %b %b %h want 1 0 %h", bus.issue0_valid, bus.issue1_valid, bus.issue0_instr, lw); end
        apply(1'b0, 1'b0, 1'b0, add, nx);
        for (int k = 0; k < LL; k++) begin
            #4;
            n_cmp++; if ({bus.freeze1, bus.freeze2, bus.dependency_on_ins2} !== 3'b100) begin
                n_bad++; $display("FAIL load_freeze%0d: got %b want 100", k, {bus.freeze1, bus.freeze2, bus.dependency_on_ins2}); end
            tick();
            n_cmp++; if ({bus.issue0_valid, bus.issue1_valid} !== 2'b00) begin
                n_bad++; $display("FAIL load_bubble%0d: got %b want 00", k, {bus.issue0_valid, bus.issue1_valid}); end
        end
        #4;
        n_cmp++; if ({bus.freeze1, bus.freeze2, bus.dependency_on_ins2} !== 3'b000) begin
            n_bad++; $display("FAIL load_release: got %b want 000", {bus.freeze1, bus.freeze2, bus.dependency_on_ins2}); end
        tick();
        n_cmp++; if ({bus.issue0_valid, bus.issue1_valid, bus.issue0_instr, bus.issue1_instr} !== {2'b11, add, nx}) begin
            n_bad++; $display("FAIL load_after: got %b %b %h %h want 1 1 %h %h", bus.issue0_valid, bus.issue1_valid,
                              bus.issue0_instr, bus.issue1_instr, add, nx); end
    endtask

    task automatic test_single();
        logic [31:0] pa [4];
        logic [31:0] pb [4];
        logic [2:0] ec [4];
        do_reset();
        pa = '{enc(O_BR, 0, 0, 0), enc(O_LOAD, 1, 2, 0), enc(O_IMM, 7, 0, 1), enc(O_IMM, 2, 0, 1)};
        pb = '{enc(O_IMM, 2, 0, 2), enc(O_STORE, 0, 4, 3), enc(O_LOAD, 8, 0, 0), 32'd0};
        ec = '{3'b001, 3'b001, 3'b000, 3'b001};
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 1'b0, 1'b0, pa[k], pb[k]);
            #4;
            n_cmp++; if ({bus.freeze1, bus.freeze2, bus.dependency_on_ins2} !== ec[k]) begin
                n_bad++; $display("FAIL single_comb%0d: got %b want %b", k, {bus.freeze1, bus.freeze2, bus.dependency_on_ins2}, ec[k]); end
            tick();
            n_cmp++; if ({bus.issue0_valid, bus.issue1_valid, bus.issue0_instr} !== {1'b1, ~ec[k][0], pa[k]}) begin
                n_bad++; $display("FAIL single_issue%0d: got %b %b %h want 1 %b %h", k, bus.issue0_valid, bus.issue1_valid,
                                  bus.issue0_instr, ~ec[k][0], pa[k]); end
        end
    endtask

    task automatic test_stall_flush();
        logic [31:0] a, b, lw;
        do_reset();
        a = enc(O_IMM, 1, 0, 1);
        b = enc(O_IMM, 2, 0, 2);
        lw = enc(O_LOAD, 5, 0, 0);
        apply(1'b0, 1'b0, 1'b0, a, b);
        tick();
        apply(1'b0, 1'b0, 1'b1, lw, enc(O_OP, 6, 5, 0));
        for (int k = 0; k < 3; k++) begin
            #4;
            n_cmp++; if ({bus.freeze1, bus.freeze2, bus.dependency_on_ins2} !== 3'b010) begin
                n_bad++; $display("FAIL stall_comb%0d: got %b want 010", k, {bus.freeze1, bus.freeze2, bus.dependency_on_ins2}); end
            tick();
            n_cmp++; if ({bus.issue0_valid, bus.issue1_valid, bus.issue0_instr, bus.issue1_instr} !== {2'b11, a, b}) begin
                n_bad++; $display("FAIL stall_hold%0d: got %b %b %h %h want 1 1 %h %h", k, bus.issue0_valid, bus.issue1_valid,
                                  bus.issue0_instr, bus.issue1_instr, a, b); end
        end
        apply(1'b0, 1'b0, 1'b0, lw, enc(O_OP, 6, 5, 0));
        tick();
        apply(1'b0, 1'b1, 1'b0, enc(O_IMM, 3, 0, 3), enc(O_IMM, 4, 0, 4));
        #4;
        n_cmp++; if ({bus.freeze1, bus.freeze2, bus.dependency_on_ins2} !== 3'b000) begin
            n_bad++; $display("FAIL flush_comb: got %b want 000", {bus.freeze1, bus.freeze2, bus.dependency_on_ins2}); end
        tick();
        n_cmp++; if ({bus.issue0_valid, bus.issue1_valid} !== 2'b00) begin
            n_bad++; $display("FAIL flush_valid: got %b want 00", {bus.issue0_valid, bus.issue1_valid}); end
        apply(1'b0, 1'b0, 1'b0, enc(O_OP, 6, 5, 0), enc(O_IMM, 9, 0, 4));
        #4;
        n_cmp++; if ({bus.freeze1, bus.freeze2, bus.dependency_on_ins2} !== 3'b100) begin
            n_bad++; $display("FAIL flush_sb_kept: got %b want 100", {bus.freeze1, bus.freeze2, bus.dependency_on_ins2}); end
        tick();
        #4;
        n_cmp++; if ({bus.freeze1, bus.freeze2, bus.dependency_on_ins2} !== 3'b000) begin
            n_bad++; $display("FAIL flush_sb_drain: got %b want 000", {bus.freeze1, bus.freeze2, bus.dependency_on_ins2}); end
        tick();
    endtask

    task automatic test_async_reset();
        logic [31:0] add;
        do_reset();
        add = enc(O_OP, 6, 5, 0);
        apply(1'b0, 1'b0, 1'b0, enc(O_LOAD, 5, 0, 0), enc(O_IMM, 7, 0, 1));
        tick();
        apply(1'b0, 1'b0, 1'b0, add, enc(O_IMM, 8, 0, 3));
        #1;
        n_cmp++; if ({bus.issue0_valid, bus.issue1_valid, bus.freeze1} !== 3'b111) begin
            n_bad++; $display("FAIL areset_pre: got %b want 111", {bus.issue0_valid, bus.issue1_valid, bus.freeze1}); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.issue0_valid, bus.issue1_valid, bus.freeze1, bus.freeze2, bus.dependency_on_ins2} !== 5'b00000) begin
            n_bad++; $display("FAIL areset_clear: got %b want 00000",
                              {bus.issue0_valid, bus.issue1_valid, bus.freeze1, bus.freeze2, bus.dependency_on_ins2}); end
`ifdef SCHED_PERF_EN
        n_cmp++; if ({bus.perf_dual, bus.perf_single, bus.perf_stall} !== 96'd0) begin
            n_bad++; $display("FAIL areset_perf: got %0d %0d %0d want 0 0 0", bus.perf_dual, bus.perf_single, bus.perf_stall); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++; if ({bus.issue0_valid, bus.issue1_valid, bus.issue0_instr} !== {2'b11, add}) begin
            n_bad++; $display("FAIL areset_resume: got %b %b %h want 1 1 %h", bus.issue0_valid, bus.issue1_valid, bus.issue0_instr, add); end
    endtask

    task automatic test_random();
        logic nf, fl, st, kill;
        logic [31:0] a, b;
        logic [2:0] ec;
        int n, nn, s1, s2, d;
        bit ld, mem, ctl;
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            nf = $urandom_range(0, 9) == 0;
            fl = $urandom_range(0, 19) == 0;
            st = $urandom_range(0, 6) == 0;
            a = rnd_instr();
            b = rnd_instr();
            apply(nf, fl, st, a, b);
            #4;
            kill = nf || fl;
            n = model_n(a, b);
            ec = {!kill && !st && n == 0, !kill && st, !kill && !st && n == 1};
            n_cmp++; if ({bus.freeze1, bus.freeze2, bus.dependency_on_ins2} !== ec) begin
                n_bad++; $display("FAIL rand_comb t=%0d: got %b want %b (i0=%h i1=%h)", t,
                                  {bus.freeze1, bus.freeze2, bus.dependency_on_ins2}, ec, a, b); end
            nn = (kill || st) ? 0 : n;
            if (kill) begin
                ev0 = 1'b0;
                ev1 = 1'b0;
            end else if (!st) begin
                ev0 = nn > 0;
                ev1 = nn > 1;
                if (nn > 0) ei0 = a;
                if (nn > 1) ei1 = b;
            end
            if (nn > 0) begin dec(a, s1, s2, d, ld, mem, ctl); if (ld && d != 0) ready[d] = cyc + 1 + LL; end
            if (nn > 1) begin dec(b, s1, s2, d, ld, mem, ctl); if (ld && d != 0) ready[d] = cyc + 1 + LL; end
            if (!nf) begin
                if (nn == 2) m_dual++;
                else if (nn == 1) m_single++;
                else m_stall++;
            end
            cyc++;
            tick();
            n_cmp++; if ({bus.issue0_valid, bus.issue1_valid} !== {ev0, ev1}) begin
                n_bad++; $display("FAIL rand_valid t=%0d: got %b want %b", t, {bus.issue0_valid, bus.issue1_valid}, {ev0, ev1}); end
            if (ev0) begin
                n_cmp++; if (bus.issue0_instr !== ei0) begin
                    n_bad++; $display("FAIL rand_i0 t=%0d: got %h want %h", t, bus.issue0_instr, ei0); end
            end
            if (ev1) begin
                n_cmp++; if (bus.issue1_instr !== ei1) begin
                    n_bad++; $display("FAIL rand_i1 t=%0d: got %h want %h", t, bus.issue1_instr, ei1); end
            end
        end
`ifdef SCHED_PERF_EN
        n_cmp++; if ({bus.perf_dual, bus.perf_single, bus.perf_stall} !== {32'(m_dual), 32'(m_single), 32'(m_stall)}) begin
            n_bad++; $display("FAIL rand_perf: got %0d %0d %0d want %0d %0d %0d", bus.perf_dual, bus.perf_single,
                              bus.perf_stall, m_dual, m_single, m_stall); end
`endif
    endtask

    initial begin
        test_reset();
        test_dual();
        test_dep();
        test_load_hazard();
        test_single();
        test_stall_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
